// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory stage (master) and a multi-cycle data memory (slave).
// Single-beat req/ack handshake; the request fields stay stable until mem_ack.
interface mem_access_stage_if #(
  parameter int ADDR_W = 64
) ();
  localparam int STRB_W = ADDR_W / 8;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage of the 64-bit pipeline: issues loads/stores over a req/ack bus, aligns and
// extends load data, and feeds MEM/WB with registered results. Optional watchdog: MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic                Mem_Read,
  input  logic                Mem_Write,
  input  logic [2:0]          funct3,
  input  logic [1:0]          WB,
  input  logic [ADDR_W-1:0]   Mem_Address,
  input  logic [ADDR_W-1:0]   Write_Data,
  input  logic [4:0]          rd,
  output logic                stall,
  mem_access_stage_if.master  mem,
  output logic                valid_out,
  output logic [1:0]          WB_out,
  output logic [ADDR_W-1:0]   Read_Data,
  output logic [4:0]          rd_out,
  output logic [ADDR_W-1:0]   Mem_Address_out,
  output logic                misalign
);

  localparam int STRB_W = ADDR_W / 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    logic r;
    case (f3)
      3'b000, 3'b100: r = 1'b0;
      3'b001, 3'b101: r = off[0];
      3'b010, 3'b110: r = |off[1:0];
      3'b011:         r = |off;
      default:        r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [STRB_W-1:0] store_strobe(input logic [2:0] f3, input logic [2:0] off);
    logic [STRB_W-1:0] s;
    case (f3[1:0])
      2'b00:   s = STRB_W'(8'h01) << off;
      2'b01:   s = STRB_W'(8'h03) << off;
      2'b10:   s = STRB_W'(8'h0F) << off;
      2'b11:   s = STRB_W'(8'hFF);
      default: s = {STRB_W{1'b0}};
    endcase
    return s;
  endfunction

  // Input is the doubleword already shifted so the addressed byte sits in bits [7:0].
  function automatic logic [ADDR_W-1:0] load_extend(input logic [2:0] f3, input logic [ADDR_W-1:0] d);
    logic [ADDR_W-1:0] r;
    case (f3)
      3'b000:  r = {{(ADDR_W-8){d[7]}},   d[7:0]};
      3'b001:  r = {{(ADDR_W-16){d[15]}}, d[15:0]};
      3'b010:  r = {{(ADDR_W-32){d[31]}}, d[31:0]};
      3'b011:  r = d;
      3'b100:  r = {{(ADDR_W-8){1'b0}},   d[7:0]};
      3'b101:  r = {{(ADDR_W-16){1'b0}},  d[15:0]};
      3'b110:  r = {{(ADDR_W-32){1'b0}},  d[31:0]};
      default: r = {ADDR_W{1'b0}};
    endcase
    return r;
  endfunction

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                valid_out_q, valid_out_d;
  logic [1:0]          wb_out_q, wb_out_d;
  logic [ADDR_W-1:0]   read_data_q, read_data_d;
  logic [4:0]          rd_out_q, rd_out_d;
  logic [ADDR_W-1:0]   mem_address_out_q, mem_address_out_d;
  logic                misalign_q, misalign_d;
  logic [1:0]          hold_wb_q, hold_wb_d;
  logic [4:0]          hold_rd_q, hold_rd_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic [2:0]          hold_f3_q, hold_f3_d;

  logic [2:0]          off_s;
  logic                is_mem_s;
  logic                misaligned_s;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
`else
  logic [31:0]         unused_tmo_s;
  assign unused_tmo_s = 32'(TIMEOUT_CYCLES);
`endif

  assign off_s        = Mem_Address[2:0];
  assign is_mem_s     = Mem_Read | Mem_Write;
  assign misaligned_s = is_misaligned(funct3, off_s);

  assign stall           = (state_q == ACCESS);
  assign mem.mem_req     = mem_req_q;
  assign mem.mem_we      = mem_we_q;
  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_wdata   = mem_wdata_q;
  assign mem.mem_wstrb   = mem_wstrb_q;
  assign valid_out       = valid_out_q;
  assign WB_out          = wb_out_q;
  assign Read_Data       = read_data_q;
  assign rd_out          = rd_out_q;
  assign Mem_Address_out = mem_address_out_q;
  assign misalign        = misalign_q;

  // Next-state and next-output logic; valid/WB/misalign default to a bubble every cycle.
  always_comb begin
    state_d           = state_q;
    mem_req_d         = mem_req_q;
    mem_we_d          = mem_we_q;
    mem_addr_d        = mem_addr_q;
    mem_wdata_d       = mem_wdata_q;
    mem_wstrb_d       = mem_wstrb_q;
    valid_out_d       = 1'b0;
    wb_out_d          = 2'b00;
    read_data_d       = read_data_q;
    rd_out_d          = rd_out_q;
    mem_address_out_d = mem_address_out_q;
    misalign_d        = 1'b0;
    hold_wb_d         = hold_wb_q;
    hold_rd_d         = hold_rd_q;
    hold_addr_d       = hold_addr_q;
    hold_f3_d         = hold_f3_q;
`ifdef MEM_TIMEOUT_EN
    tmo_cnt_d         = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem_s) begin
            valid_out_d       = 1'b1;
            wb_out_d          = WB;
            rd_out_d          = rd;
            mem_address_out_d = Mem_Address;
            read_data_d       = {ADDR_W{1'b0}};
          end else if (misaligned_s) begin
            valid_out_d       = 1'b1;
            misalign_d        = 1'b1;
            rd_out_d          = rd;
            mem_address_out_d = Mem_Address;
          end else begin
            // A store wins when both Mem_Read and Mem_Write are set.
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = Mem_Write;
            mem_addr_d  = {Mem_Address[ADDR_W-1:3], 3'b000};
            mem_wdata_d = Write_Data << {off_s, 3'b000};
            mem_wstrb_d = Mem_Write ? store_strobe(funct3, off_s) : {STRB_W{1'b0}};
            hold_wb_d   = WB;
            hold_rd_d   = rd;
            hold_addr_d = Mem_Address;
            hold_f3_d   = funct3;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_d   = {TMO_W{1'b0}};
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (mem.mem_ack) begin
          state_d           = IDLE;
          mem_req_d         = 1'b0;
          valid_out_d       = 1'b1;
          wb_out_d          = hold_wb_q;
          rd_out_d          = hold_rd_q;
          mem_address_out_d = hold_addr_q;
          read_data_d       = mem_we_q ? {ADDR_W{1'b0}}
                                       : load_extend(hold_f3_q, mem.mem_rdata >> {hold_addr_q[2:0], 3'b000});
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (tmo_cnt_q == TMO_LAST) begin
            state_d           = IDLE;
            mem_req_d         = 1'b0;
            valid_out_d       = 1'b1;
            misalign_d        = 1'b1;
            rd_out_d          = hold_rd_q;
            mem_address_out_d = hold_addr_q;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
`else
          state_d = ACCESS;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any outstanding access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      mem_req_q         <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= {ADDR_W{1'b0}};
      mem_wdata_q       <= {ADDR_W{1'b0}};
      mem_wstrb_q       <= {STRB_W{1'b0}};
      valid_out_q       <= 1'b0;
      wb_out_q          <= 2'b00;
      read_data_q       <= {ADDR_W{1'b0}};
      rd_out_q          <= 5'd0;
      mem_address_out_q <= {ADDR_W{1'b0}};
      misalign_q        <= 1'b0;
      hold_wb_q         <= 2'b00;
      hold_rd_q         <= 5'd0;
      hold_addr_q       <= {ADDR_W{1'b0}};
      hold_f3_q         <= 3'b000;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q         <= {TMO_W{1'b0}};
`endif
    end else begin
      state_q           <= state_d;
      mem_req_q         <= mem_req_d;
      mem_we_q          <= mem_we_d;
      mem_addr_q        <= mem_addr_d;
      mem_wdata_q       <= mem_wdata_d;
      mem_wstrb_q       <= mem_wstrb_d;
      valid_out_q       <= valid_out_d;
      wb_out_q          <= wb_out_d;
      read_data_q       <= read_data_d;
      rd_out_q          <= rd_out_d;
      mem_address_out_q <= mem_address_out_d;
      misalign_q        <= misalign_d;
      hold_wb_q         <= hold_wb_d;
      hold_rd_q         <= hold_rd_d;
      hold_addr_q       <= hold_addr_d;
      hold_f3_q         <= hold_f3_d;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q         <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Data-memory stage of the 64-bit pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the memory-stage control and operands, runs loads and stores against a multi-cycle data memory through a req/ack handshake, and aligns and extends load data.
- Produces registered WB, Read_Data, rd and Mem_Address values that feed MEM/WB directly. Stalls upstream while an access is outstanding.

Parameters:
- ADDR_W, 64, width of the address and data paths.
- TIMEOUT_CYCLES, 255, watchdog limit in ACCESS state. Used only with the optional feature.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- Mem_Read  in  1  load
- Mem_Write  in  1  store
- funct3  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal
- WB  in  2  [0]=Mem_to_Reg, [1]=Reg_Write
- Mem_Address  in  64  effective address from the ALU
- Write_Data  in  64  store data, right-justified
- rd  in  5  destination register
- stall  out  1  upstream must hold its registers
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  64  doubleword-aligned address, {Mem_Address[63:3],3'b000}
- mem_wdata  out  64  lane-positioned store data
- mem_wstrb  out  8  byte strobes
- mem_ack  in  1  single-cycle completion
- mem_rdata  in  64  read doubleword, valid with mem_ack
- valid_out  out  1  outputs carry a retired instruction this cycle
- WB_out  out  2  to MEM/WB WB; 2'b00 = bubble
- Read_Data  out  64  extended load data
- rd_out  out  5
- Mem_Address_out  out  64  unmodified effective address (ALU result path)
- misalign  out  1  one-cycle fault pulse

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. All state and outputs are updated only on posedge clk.
- Reset values:
  - state=IDLE; stall=0; mem_req=0; mem_we=0; mem_wstrb=0.
  - valid_out=0; WB_out=00; misalign=0.
  - Read_Data=0; rd_out=0; Mem_Address_out=0; mem_addr=0; mem_wdata=0.
- Reset while in ACCESS aborts the access. mem_req is 0 in the cycle after the reset edge. A mem_ack arriving in or after the reset cycle is ignored.
- States: IDLE, ACCESS.
- Alignment: off=Mem_Address[2:0].
  - Misaligned when H and off[0]!=0; W and off[1:0]!=0; D and off!=0.
  - funct3=111 with Mem_Read or Mem_Write is treated as misaligned.
- IDLE, ex_valid=0: next edge valid_out=0, WB_out=00. Other data outputs hold.
- IDLE, ex_valid=1 and no Mem_Read/Mem_Write: 1-cycle pass-through.
  - Next edge: valid_out=1, WB_out=WB, rd_out=rd, Mem_Address_out=Mem_Address, Read_Data=0.
- IDLE, ex_valid=1 with a memory op, misaligned:
  - No memory request is issued.
  - Next edge: valid_out=1, WB_out=00, misalign=1 for one cycle, rd_out/Mem_Address_out captured.
- IDLE, ex_valid=1 with a memory op, aligned:
  - Next edge: state=ACCESS, mem_req=1, mem_we=Mem_Write, mem_addr aligned.
  - WB, rd, Mem_Address and funct3 are captured into holding registers. valid_out=0.
  - Store strobes: B 8'h01<<off, H 8'h03<<off, W 8'h0F<<off, D 8'hFF.
  - Store data: mem_wdata=Write_Data<<(8*off). Bytes outside the strobe are don't-care.
  - Mem_Read and Mem_Write both set: the store wins.
- ACCESS:
  - stall=1 (combinational from state). Upstream inputs are ignored.
  - mem_req and all mem_* outputs are held stable until mem_ack.
- ACCESS, mem_ack=1 at an edge:
  - That edge: mem_req=0, state=IDLE, valid_out=1.
  - WB_out, rd_out and Mem_Address_out come from the holding registers.
  - Load: Read_Data = (mem_rdata>>(8*off)), truncated to the size and sign- or zero-extended per funct3.
  - Store: Read_Data=0.
  - stall falls in the following cycle.
- Latency: pass-through 1 cycle. Memory op = 1 cycle to request, plus N wait cycles, plus the output on the ack edge. The minimum is ack in the first ACCESS cycle, giving 2 cycles.
- mem_ack while in IDLE is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES: mem_req=0, state=IDLE, valid_out=1, WB_out=00, misalign=1 for one cycle.
- Not defined: no counter. ACCESS waits indefinitely for mem_ack.

Test Plan:
- Reset then pass-through: R-type ex_valid=1, WB=10, rd=5, Mem_Address=0x1234 → next cycle valid_out=1, WB_out=10, rd_out=5, Mem_Address_out=0x1234, stall=0, mem_req=0.
- Signed byte load: LB, addr 0x1003; memory acks 3 cycles after request with rdata 0x00000000_80000000 → mem_addr=0x1000; stall high through ACCESS; Read_Data=0xFFFFFFFF_FFFFFF80 (byte 3=0x80); WB_out=WB.
- Unsigned half load: LHU, addr 0x2006, rdata 0xBEEF_0000_0000_0000 → Read_Data=0x000000000000BEEF.
- Word store: SW, addr 0x3004, Write_Data=0xDEADBEEF → mem_we=1, mem_wstrb=8'hF0, mem_wdata[63:32]=0xDEADBEEF; after ack WB_out=WB, Read_Data=0.
- Misaligned: LD at 0x4002 → no mem_req, misalign pulse, WB_out=00. With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no ack → abort after 4 ACCESS cycles, misalign=1.
- Reset asserted in the 2nd ACCESS cycle, then ack one cycle later → mem_req=0 after reset; ack ignored; valid_out stays 0.
